spi_host: RTL and testbench
===========================

# spi_host

Host-side (initiator) SPI/QSPI engine that drives `p_ck`/`p_ncs` and the four data lanes of an external SPI target, e.g. the `sphy`-based target chip. It serialises bytes from a valid/ready stream into SPI mode 0 frames in single-lane full-duplex or quad-lane half-duplex mode, and returns one captured byte per transferred byte. It sits between a controller/sequencer and the bidirectional pad cells (`p_se`/`p_so`/`p_si` map onto the pad output-enable, output and input).

## Interface
- `DIV`, 2: SCK half-period in `ck` cycles, ≥1; SCK period = 2·DIV cycles.
- `CSS`, 2: `p_ncs` fall to first SCK rise, in `ck` cycles, ≥1.
- `CSH`, 2: last SCK fall to `p_ncs` rise, in `ck` cycles, ≥1.
- `ck`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `t_valid`  in  1  byte request valid.
- `t_ready`  out  1  byte request accepted when `t_valid & t_ready`.
- `t_data`  in  8  byte to send, MSB first.
- `t_last`  in  1  raise `p_ncs` after this byte.
- `t_quad`  in  1  1 = quad lanes, 0 = single lane.
- `t_dir`  in  1  quad only: 1 = write (drive lanes), 0 = read (tristate).
- `r_valid`  out  1  one-cycle pulse, byte finished.
- `r_data`  out  8  byte captured during that transfer.
- `busy`  out  1  high whenever `p_ncs` is low or a CSH/gap phase is running.
- `p_ck`  out  1  SCK, idle low.
- `p_ncs`  out  1  chip select, active low.
- `p_se`  out  4  per-lane output enable.
- `p_so`  out  4  per-lane output data.
- `p_si`  in  4  per-lane input data.

## Operation
- States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- IDLE: `p_ncs`=1, `t_ready`=1. Accepting a byte latches `t_data`, `t_last`, `t_quad`, `t_dir`, drives `p_ncs` low, and moves to SETUP.
- SETUP: count CSS cycles with the first bit/nibble already on `p_so`, then SHIFT.
- SHIFT: SPI mode 0. `p_ck` rises after DIV cycles low and falls after DIV cycles high. Sample `p_si` on the cycle `p_ck` goes high; shift the output on the cycle it goes low.
- Single lane: 8 SCK periods. `p_so[0]` carries data; `p_si[1]` is sampled; `p_se`=4'b0001; `t_dir` is ignored.
- Quad lane: 2 SCK periods, high nibble first on `p_so[3:0]`, `p_si[3:0]` sampled.
  - `p_se`=4'hF if `t_dir`=1, else 4'h0.
  - `r_data` is still captured during writes; the consumer ignores it.
- End of byte (final SCK fall):
  - `r_valid` pulses with `r_data`.
  - If the byte was `t_last`, go to HOLD.
  - Otherwise `t_ready`=1 in that same cycle. If `t_valid`, load the next byte and continue SHIFT with no extra SCK gap. If not, go to WAIT.
- WAIT: `p_ck`=0, `p_ncs`=0, `p_se` holds, `t_ready`=1. Accepting a byte re-enters SHIFT after DIV low cycles.
- HOLD: CSH cycles, then `p_ncs`=1, `p_se`=0, go to GAP.
- GAP: `p_ncs` stays high for DIV cycles, then IDLE.
- Mode/direction may change per byte within one frame. Lanes switch at the byte boundary, on the SCK fall.

## Timing
- Reset values: `p_ncs`=1, `p_ck`=0, `p_se`=0, `p_so`=0, `r_valid`=0, `r_data`=0, `t_ready`=0 while `rst` is high, `busy`=0. State = IDLE.
- `rst` mid-frame: next cycle all outputs take their reset values. The partial byte is discarded and no `r_valid` is issued.
- All pad outputs come straight from flops.
- Latency, IDLE accept to first SCK rise: CSS+DIV cycles.
- Byte duration: 16·DIV cycles single, 4·DIV cycles quad.
- `r_valid` fires in the cycle of the final SCK fall. `r_data` holds until the next `r_valid`.
- Min `p_ncs` high time between frames: DIV cycles.
- There is no backpressure on `r_*`.

## Configuration
- `SPI_HOST_QUAD_EN` defined: quad mode as described.
- Undefined: `t_quad` and `t_dir` are ignored. Every byte runs single-lane full-duplex; `p_se[3:1]`=0 and `p_so[3:1]`=0 always.

## Structure
- Package `spi_host_pkg`: state enum, lane-enable constants (`SE_SINGLE`=4'b0001, `SE_QUAD_W`=4'hF, `SE_OFF`=4'h0), bits-per-byte constants (8/2 SCK periods).
- Sub-module `spi_host_div`: SCK half-period counter. Produces one-cycle `rise`/`fall` strobes; cleared on `rst` and on state entry.

## Test plan
- Single byte, single lane, DIV=2, `t_data`=8'hA5, `t_last`=1, target echoes 8'h3C on `p_si[1]`:
  - `p_so[0]` shows 1,0,1,0,0,1,0,1 on 8 rises.
  - `r_data`=8'h3C.
  - `p_ncs` low for CSS+32+CSH cycles.
- Quad write 8'h9F then quad read, no `t_valid` gap:
  - 4 SCK periods total; nibbles 9, F on lanes.
  - `p_se` goes 4'hF→4'h0 at the boundary fall.
  - Read byte = `p_si` nibbles 4'h6, 4'h1 → `r_data`=8'h61.
- `t_valid` dropped for 10 cycles mid-frame: WAIT holds `p_ck`=0 and `p_ncs`=0, then resumes with no glitch on `p_ck`.
- `rst` asserted at SCK period 3 of a byte: next cycle `p_ncs`=1, `p_se`=0, no `r_valid`. Next request starts cleanly from SETUP.
- Two frames back-to-back (both `t_last`): `p_ncs` high ≥DIV cycles between them. `busy` falls exactly on return to IDLE.
- Build without `SPI_HOST_QUAD_EN`, `t_quad`=1: byte runs 8 periods single-lane and `p_se`=4'b0001.

Source files
------------

// File: rtl/spi_host_pkg.sv
// Shared types and constants for the SPI/QSPI host engine: FSM states,
// lane-enable patterns, SCK periods per byte and lane packing helpers.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } state_t;

    localparam logic [3:0] SE_SINGLE = 4'b0001;
    localparam logic [3:0] SE_QUAD_W = 4'hF;
    localparam logic [3:0] SE_OFF    = 4'h0;

    localparam int PERIODS_SINGLE = 8;
    localparam int PERIODS_QUAD   = 2;

    function automatic logic [3:0] lane_enable(input logic quad, input logic dir);
        return quad ? (dir ? SE_QUAD_W : SE_OFF) : SE_SINGLE;
    endfunction

    // Bits presented on the lanes for the leading end of a byte (MSB first).
    function automatic logic [3:0] lanes_out(input logic quad, input logic [7:0] b);
        return quad ? b[7:4] : {3'b000, b[7]};
    endfunction

    function automatic logic [7:0] shift_byte(input logic quad, input logic [7:0] b);
        return quad ? {b[3:0], 4'h0} : {b[6:0], 1'b0};
    endfunction

endpackage

// File: rtl/spi_host_if.sv
// Byte request / captured byte stream between a sequencer (master) and
// the SPI host engine (slave).
interface spi_host_if;
    logic       t_valid;
    logic       t_ready;
    logic [7:0] t_data;
    logic       t_last;
    logic       t_quad;
    logic       t_dir;
    logic       r_valid;
    logic [7:0] r_data;

    modport master (
        output t_valid, t_data, t_last, t_quad, t_dir,
        input  t_ready, r_valid, r_data
    );

    modport slave (
        input  t_valid, t_data, t_last, t_quad, t_dir,
        output t_ready, r_valid, r_data
    );
endinterface

// File: rtl/spi_host_div.sv
// SCK half-period counter: emits one-cycle rise/fall strobes every DIV
// enabled cycles, alternating, always starting with a low half.
module spi_host_div #(
    parameter int DIV = 2
) (
    input  logic ck,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic rise,
    output logic fall
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;
    logic          phase_reg;
    logic          tick;

    assign tick = en && (cnt_reg == CW'(DIV - 1));
    assign rise = tick && !phase_reg;
    assign fall = tick && phase_reg;

    always_ff @(posedge ck) begin
        if (rst || clr) begin
            cnt_reg   <= '0;
            phase_reg <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt_reg   <= '0;
                phase_reg <= !phase_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_host.sv
// SPI mode 0 host engine, single-lane full duplex or quad-lane half duplex.
// Quad support is compiled in only when SPI_HOST_QUAD_EN is defined.
module spi_host
    import spi_host_pkg::*;
#(
    parameter int DIV = 2,
    parameter int CSS = 2,
    parameter int CSH = 2
) (
    input  logic       ck,
    input  logic       rst,
    spi_host_if.slave  bus,
    output logic       busy,
    output logic       p_ck,
    output logic       p_ncs,
    output logic [3:0] p_se,
    output logic [3:0] p_so,
    input  logic [3:0] p_si
);
    localparam int TW = 16;

    state_t     state_reg, state_next;
    logic [TW-1:0] timer_reg;
    logic [7:0] tx_reg, rx_reg;
    logic [2:0] per_cnt_reg;
    logic       quad_reg, last_reg;
    logic       p_ck_reg, p_ncs_reg, r_valid_reg;
    logic [3:0] p_se_reg, p_so_reg;
    logic [7:0] r_data_reg;

    logic       t_ready_next, load, byte_end, last_period;
    logic       quad_in, dir_in;
    logic       rise, fall;

`ifdef SPI_HOST_QUAD_EN
    assign quad_in = bus.t_quad;
    assign dir_in  = bus.t_dir;
`else
    logic unused_cfg;
    assign unused_cfg = ^{bus.t_quad, bus.t_dir};
    assign quad_in    = 1'b0;
    assign dir_in     = 1'b0;
`endif

    assign last_period = (per_cnt_reg == (quad_reg ? 3'(PERIODS_QUAD - 1)
                                                   : 3'(PERIODS_SINGLE - 1)));

    spi_host_div #(.DIV(DIV)) u_div (
        .ck   (ck),
        .rst  (rst),
        .clr  (state_next != state_reg),
        .en   (state_reg == SHIFT),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge ck) begin
        if (rst) begin
            state_reg <= IDLE;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            timer_reg <= (state_next != state_reg) ? '0 : timer_reg + 1'b1;
        end
    end

    always_comb begin
        state_next   = state_reg;
        t_ready_next = 1'b0;
        load         = 1'b0;
        byte_end     = 1'b0;
        case (state_reg)
            IDLE: begin
                t_ready_next = 1'b1;
                if (bus.t_valid) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: if (timer_reg == TW'(CSS - 1)) state_next = SHIFT;
            SHIFT: begin
                // Byte boundary: the next byte is taken on the same edge as
                // the final SCK fall so back-to-back bytes have no SCK gap.
                if (fall && last_period) begin
                    byte_end = 1'b1;
                    if (last_reg) begin
                        state_next = HOLD;
                    end else begin
                        t_ready_next = 1'b1;
                        if (bus.t_valid) load = 1'b1;
                        else             state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                t_ready_next = 1'b1;
                if (bus.t_valid) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            HOLD: if (timer_reg == TW'(CSH - 1)) state_next = GAP;
            GAP:  if (timer_reg == TW'(DIV - 1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            tx_reg      <= '0;
            rx_reg      <= '0;
            per_cnt_reg <= '0;
            quad_reg    <= 1'b0;
            last_reg    <= 1'b0;
            p_ck_reg    <= 1'b0;
            p_ncs_reg   <= 1'b1;
            p_se_reg    <= SE_OFF;
            p_so_reg    <= '0;
            r_valid_reg <= 1'b0;
            r_data_reg  <= '0;
        end else begin
            r_valid_reg <= byte_end;
            if (byte_end) r_data_reg <= rx_reg;

            if (load) begin
                tx_reg      <= shift_byte(quad_in, bus.t_data);
                p_so_reg    <= lanes_out(quad_in, bus.t_data);
                p_se_reg    <= lane_enable(quad_in, dir_in);
                quad_reg    <= quad_in;
                last_reg    <= bus.t_last;
                per_cnt_reg <= '0;
            end else if (fall) begin
                tx_reg      <= shift_byte(quad_reg, tx_reg);
                p_so_reg    <= lanes_out(quad_reg, tx_reg);
                per_cnt_reg <= per_cnt_reg + 1'b1;
            end

            if (rise) begin
                p_ck_reg <= 1'b1;
                rx_reg   <= quad_reg ? {rx_reg[3:0], p_si} : {rx_reg[6:0], p_si[1]};
            end else if (fall) begin
                p_ck_reg <= 1'b0;
            end

            if (state_reg == IDLE && load) p_ncs_reg <= 1'b0;
            if (state_reg == HOLD && state_next == GAP) begin
                p_ncs_reg <= 1'b1;
                p_se_reg  <= SE_OFF;
                p_so_reg  <= '0;
            end
        end
    end

    assign bus.t_ready = t_ready_next && !rst;
    assign bus.r_valid = r_valid_reg;
    assign bus.r_data  = r_data_reg;
    assign busy        = (state_reg != IDLE);
    assign p_ck        = p_ck_reg;
    assign p_ncs       = p_ncs_reg;
    assign p_se        = p_se_reg;
    assign p_so        = p_so_reg;
endmodule

// File: tb/tb_spi_host.sv
// Randomised bench for spi_host: a transaction-level model predicts lane
// values per SCK rise, captured bytes and per-frame chip-select timing.
module tb_spi_host;
    localparam int DIV = 2;
    localparam int CSS = 3;
    localparam int CSH = 2;
`ifdef SPI_HOST_QUAD_EN
    localparam bit QUAD_EN = 1'b1;
`else
    localparam bit QUAD_EN = 1'b0;
`endif

    typedef struct packed {
        logic [3:0] so;
        logic [3:0] mask;
        logic [3:0] se;
        logic [3:0] si;
    } rise_t;

    typedef struct {
        int rises;
        int low;
    } frame_t;

    logic       ck = 1'b0;
    logic       rst = 1'b1;
    logic       busy, p_ck, p_ncs;
    logic [3:0] p_se, p_so, p_si;
    spi_host_if bus ();

    int   n_vec = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    rise_t      rq[$];
    logic [7:0] dq[$];
    frame_t     fq[$];
    int   cur_rises = 0;
    int   cur_low = 0;
    bit   cur_cont = 1'b1;

    spi_host #(.DIV(DIV), .CSS(CSS), .CSH(CSH)) dut (
        .ck    (ck),
        .rst   (rst),
        .bus   (bus),
        .busy  (busy),
        .p_ck  (p_ck),
        .p_ncs (p_ncs),
        .p_se  (p_se),
        .p_so  (p_so),
        .p_si  (p_si)
    );

    always #5 ck = ~ck;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_req(input logic [7:0] d, input logic last, input logic quad, input logic dir);
        int n;
        n = 0;
        @(negedge ck);
        bus.t_valid = 1'b1;
        bus.t_data  = d;
        bus.t_last  = last;
        bus.t_quad  = quad;
        bus.t_dir   = dir;
        while (!bus.t_ready && n < 2000) begin
            @(negedge ck);
            n++;
        end
        if (!bus.t_ready) check_eq("t_ready_timeout", 0, 1);
        @(posedge ck);
        #1;
        bus.t_valid = 1'b0;
        $display("byte %02h last=%0d quad=%0d dir=%0d accepted", d, last, quad, dir);
    endtask

    // Reference: per byte, what each SCK rise must show and what the target returns.
    task automatic send(input logic [7:0] d, input logic last, input logic quad,
                        input logic dir, input logic [7:0] resp);
        logic   q;
        int     per;
        rise_t  r;
        frame_t fr;
        q   = QUAD_EN && quad;
        per = q ? 2 : 8;
        for (int i = 0; i < per; i++) begin
            if (q) begin
                r.so   = (i == 0) ? d[7:4] : d[3:0];
                r.si   = (i == 0) ? resp[7:4] : resp[3:0];
                r.se   = dir ? 4'hF : 4'h0;
                r.mask = dir ? 4'hF : 4'h0;
            end else begin
                r.so   = {3'b000, d[7-i]};
                r.si   = {2'($urandom), resp[7-i], 1'($urandom)};
                r.se   = 4'b0001;
                r.mask = QUAD_EN ? 4'b0001 : 4'b1111;
            end
            rq.push_back(r);
        end
        dq.push_back(resp);
        cur_rises += per;
        cur_low   += 2 * DIV * per;
        if (last) begin
            fr.rises = cur_rises;
            fr.low   = cur_cont ? (CSS + cur_low + CSH) : -1;
            fq.push_back(fr);
            cur_rises = 0;
            cur_low   = 0;
            cur_cont  = 1'b1;
        end
        drive_req(d, last, quad, dir);
    endtask

    task automatic wait_rvalid();
        int n;
        n = 0;
        do begin
            @(posedge ck);
            #1;
            n++;
        end while (!bus.r_valid && n < 2000);
        check_eq("r_valid_seen", bus.r_valid, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(posedge ck);
            #1;
            n++;
        end while ((busy || rq.size() != 0 || fq.size() != 0) && n < 4000);
        check_eq("idle_reached", busy, 0);
    endtask

    initial begin : monitor
        logic   pck_q, pncs_q, busy_q, fell;
        int     lo_cnt, hi_cnt, ncs_low, ncs_high, rises, gap_cnt;
        bit     gap_armed;
        rise_t  r;
        frame_t fr;
        pck_q = 1'b0; pncs_q = 1'b1; busy_q = 1'b0;
        lo_cnt = 100; hi_cnt = 0; ncs_low = 0; ncs_high = 1000; rises = 0;
        gap_cnt = 0; gap_armed = 1'b0;
        forever begin
            @(posedge ck);
            #1;
            if (!mon_en) begin
                ncs_high  = 1000;
                lo_cnt    = 100;
                hi_cnt    = 0;
                gap_armed = 1'b0;
            end else begin
                fell = pck_q && !p_ck;
                if (pncs_q && !p_ncs) begin
                    check_eq("ncs_high_min", ncs_high >= DIV, 1);
                    ncs_low = 0;
                    rises   = 0;
                end
                if (!p_ncs) ncs_low++;
                if (!pncs_q && p_ncs) begin
                    check_eq("busy_in_gap", busy, 1);
                    if (fq.size() == 0) begin
                        check_eq("frame_unexpected", 1, 0);
                    end else begin
                        fr = fq.pop_front();
                        check_eq("frame_rises", rises, fr.rises);
                        if (fr.low >= 0) check_eq("ncs_low_len", ncs_low, fr.low);
                        $display("frame end rises=%0d ncs_low=%0d", rises, ncs_low);
                    end
                    ncs_high  = 0;
                    gap_armed = 1'b1;
                    gap_cnt   = 0;
                end else if (gap_armed) begin
                    gap_cnt++;
                    if (!busy || gap_cnt > 1000) begin
                        check_eq("busy_fall_cycles", gap_cnt, DIV);
                        gap_armed = 1'b0;
                    end
                end
                if (p_ncs) ncs_high++;

                if (!pck_q && p_ck) begin
                    check_eq("sck_low_min", lo_cnt >= DIV, 1);
                    if (rises == 0) check_eq("first_rise_latency", ncs_low - 1, CSS + DIV);
                    rises++;
                    if (rq.size() == 0) begin
                        check_eq("rise_unexpected", 1, 0);
                    end else begin
                        r = rq.pop_front();
                        check_eq("p_so", p_so & r.mask, r.so & r.mask);
                        check_eq("p_se", p_se, r.se);
                    end
                    hi_cnt = 0;
                end
                if (fell) begin
                    check_eq("sck_high_width", hi_cnt, DIV);
                    lo_cnt = 0;
                end
                if (p_ck) hi_cnt++;
                else      lo_cnt++;

                if (bus.r_valid) begin
                    check_eq("rv_on_fall", fell, 1);
                    if (dq.size() == 0) check_eq("rv_unexpected", 1, 0);
                    else                check_eq("r_data", bus.r_data, dq.pop_front());
                end
            end
            pck_q  = p_ck;
            pncs_q = p_ncs;
            busy_q = busy;
            p_si   = (rq.size() != 0) ? rq[0].si : 4'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad, k, n, nb, dly;
        logic pc;
        bus.t_valid = 1'b0; bus.t_data = '0; bus.t_last = 1'b0;
        bus.t_quad = 1'b0; bus.t_dir = 1'b0; p_si = '0;
        rst = 1'b1;
        repeat (3) @(posedge ck);
        @(negedge ck);
        check_eq("rst_t_ready", bus.t_ready, 0);
        check_eq("rst_p_ncs", p_ncs, 1);
        rst = 1'b0;
        @(negedge ck);
        check_eq("idle_p_ck", p_ck, 0);
        check_eq("idle_p_se", p_se, 0);
        check_eq("idle_p_so", p_so, 0);
        check_eq("idle_r_valid", bus.r_valid, 0);
        check_eq("idle_r_data", bus.r_data, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("idle_t_ready", bus.t_ready, 1);
        mon_en = 1'b1;

        send(8'hA5, 1'b1, 1'b0, 1'b0, 8'h3C);

        send(8'h9F, 1'b0, 1'b1, 1'b1, 8'h00);
        send(8'h5A, 1'b1, 1'b1, 1'b0, 8'h61);
        check_eq("boundary_rv", bus.r_valid, 1);
        check_eq("boundary_se", p_se, QUAD_EN ? 4'h0 : 4'h1);

        send(8'h12, 1'b0, 1'b0, 1'b0, 8'hE7);
        wait_rvalid();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge ck);
            #1;
            if (p_ck || p_ncs) bad++;
        end
        check_eq("wait_lines_quiet", bad, 0);
        @(negedge ck);
        check_eq("wait_t_ready", bus.t_ready, 1);
        cur_cont = 1'b0;
        send(8'h34, 1'b1, 1'b0, 1'b0, 8'h81);

        send(8'hF0, 1'b1, 1'b0, 1'b0, 8'h0F);
        send(8'h0F, 1'b1, 1'b0, 1'b0, 8'hF0);

        send(8'hC6, 1'b1, 1'b1, 1'b1, 8'h5B);

        for (int f = 0; f < 20; f++) begin
            nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                dly = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : 0;
                if (dly > 0 && b > 0) cur_cont = 1'b0;
                repeat (dly) @(posedge ck);
                send(8'($urandom), (b == nb - 1), 1'($urandom), 1'($urandom), 8'($urandom));
            end
            repeat ($urandom_range(0, 10)) @(posedge ck);
        end
        wait_idle();

        mon_en = 1'b0;
        drive_req(8'hC3, 1'b1, 1'b0, 1'b0);
        k = 0;
        n = 0;
        pc = p_ck;
        while (k < 3 && n < 500) begin
            @(posedge ck);
            #1;
            if (p_ck && !pc) k++;
            pc = p_ck;
            n++;
        end
        check_eq("rst_reach_period3", k, 3);
        @(negedge ck);
        rst = 1'b1;
        @(posedge ck);
        #1;
        check_eq("midrst_p_ncs", p_ncs, 1);
        check_eq("midrst_p_se", p_se, 0);
        check_eq("midrst_p_ck", p_ck, 0);
        check_eq("midrst_r_valid", bus.r_valid, 0);
        check_eq("midrst_r_data", bus.r_data, 0);
        check_eq("midrst_busy", busy, 0);
        @(negedge ck);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge ck);
            #1;
            if (bus.r_valid || !p_ncs) bad++;
        end
        check_eq("postrst_quiet", bad, 0);
        $display("mid-frame reset applied");
        mon_en = 1'b1;
        @(posedge ck);

        send(8'h7E, 1'b0, 1'b0, 1'b0, 8'h42);
        send(8'hB1, 1'b1, 1'b1, 1'b1, 8'h9D);
        wait_idle();

        check_eq("left_rises", rq.size(), 0);
        check_eq("left_bytes", dq.size(), 0);
        check_eq("left_frames", fq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
